// File: rtl/tt_um_matthias_m_pal_top_wrapper_pkg.sv
// Shared sizing and bitstream layout for the 8-input, 4-term, 4-output PAL.
// Provides the OR-plane and AND-plane index helpers.
package tt_um_matthias_m_pal_top_wrapper_pkg;

  localparam int NUM_INPUTS    = 8;
  localparam int NUM_OUTPUTS   = 4;
  localparam int NUM_TERMS     = 4;
  localparam int BITSTREAM_LEN = 2 * NUM_INPUTS * NUM_TERMS + NUM_TERMS * NUM_OUTPUTS;

  localparam int OR_BASE         = 0;
  localparam int AND_BASE        = OR_BASE + NUM_TERMS * NUM_OUTPUTS;
  localparam int AND_TERM_STRIDE = 2 * NUM_INPUTS;

  typedef logic [BITSTREAM_LEN-1:0] cfg_word_t;

  // Bit that connects term t to output o.
  function automatic int or_idx(input int o, input int t);
    return OR_BASE + NUM_TERMS * o + t;
  endfunction

  // Bit that selects I[i] (neg = 0) or ~I[i] (neg = 1) into term t.
  function automatic int and_idx(input int t, input int i, input int neg);
    return AND_BASE + AND_TERM_STRIDE * t + 2 * i + neg;
  endfunction

endpackage

// File: rtl/tt_um_matthias_m_pal_top_wrapper_if.sv
// Tiny Tapeout user pin bundle; slave is the design side, master the driver side.
interface tt_um_matthias_m_pal_top_wrapper_if;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  modport slave (
    input  ui_in,
    input  uio_in,
    input  ena,
    output uo_out,
    output uio_out,
    output uio_oe
  );

  modport master (
    output ui_in,
    output uio_in,
    output ena,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

endinterface

// File: rtl/tt_um_matthias_m_pal_top_wrapper_pal_core.sv
// Serially configured PAL: shift register feeding a programmable AND plane and OR plane.
// Outputs are purely combinational from the inputs, enable and the stored configuration.
module pal_core
  import tt_um_matthias_m_pal_top_wrapper_pkg::*;
#(
  parameter int N_IN   = NUM_INPUTS,
  parameter int N_OUT  = NUM_OUTPUTS,
  parameter int N_TERM = NUM_TERMS,
  parameter int SR_LEN = 2 * N_IN * N_TERM + N_TERM * N_OUT
) (
  input  logic             cfg_clk,
  input  logic             rst_n,
  input  logic             cfg_data,
  input  logic             enable,
  input  logic [N_IN-1:0]  pal_in,
  output logic [N_OUT-1:0] pal_out
);

  logic [SR_LEN-1:0] sr;
  logic [N_TERM-1:0] term;
  logic [N_OUT-1:0]  or_out;

  // Bit 0 is shifted in first, so new bits enter at the top and walk down.
  always_ff @(posedge cfg_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {cfg_data, sr[SR_LEN-1:1]};
    end
  end

  // An unprogrammed term has no literals and therefore evaluates to 1.
  always_comb begin
    term = '1;
    for (int t = 0; t < N_TERM; t++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (sr[and_idx(t, i, 0)] && !pal_in[i]) term[t] = 1'b0;
        if (sr[and_idx(t, i, 1)] &&  pal_in[i]) term[t] = 1'b0;
      end
    end
  end

  always_comb begin
    or_out = '0;
    for (int o = 0; o < N_OUT; o++) begin
      for (int t = 0; t < N_TERM; t++) begin
        if (sr[or_idx(o, t)] && term[t]) or_out[o] = 1'b1;
      end
    end
  end

  assign pal_out = enable ? or_out : '0;

endmodule

// File: rtl/tt_um_matthias_m_pal_top_wrapper.sv
// Tiny Tapeout top: maps pins onto pal_core and ties off unused outputs.
// cfg_clk (uio_in[2]) is the only functional clock; the tile clk is not used.
module tt_um_matthias_m_pal_top_wrapper
  import tt_um_matthias_m_pal_top_wrapper_pkg::*;
(
  input logic                             clk,
  input logic                             rst_n,
  tt_um_matthias_m_pal_top_wrapper_if.slave pins
);

  logic [NUM_OUTPUTS-1:0] pal_out;
  logic                   unused_ok;

  pal_core #(
    .N_IN   (NUM_INPUTS),
    .N_OUT  (NUM_OUTPUTS),
    .N_TERM (NUM_TERMS),
    .SR_LEN (BITSTREAM_LEN)
  ) u_pal_core (
    .cfg_clk  (pins.uio_in[2]),
    .rst_n    (rst_n),
    .cfg_data (pins.uio_in[0]),
    .enable   (pins.uio_in[1]),
    .pal_in   (pins.ui_in),
    .pal_out  (pal_out)
  );

  assign pins.uo_out  = {{(8 - NUM_OUTPUTS){1'b0}}, pal_out};
  assign pins.uio_out = 8'h00;
  assign pins.uio_oe  = 8'h00;

  assign unused_ok = &{1'b0, clk, pins.ena, pins.uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_matthias_m_pal_top_wrapper.sv
// Bench for the PAL wrapper: directed scenarios plus randomized configurations
// compared against a mask-based behavioural model of the PAL equations.
module tb_tt_um_matthias_m_pal_top_wrapper;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tt_um_matthias_m_pal_top_wrapper_if bus ();

  tt_um_matthias_m_pal_top_wrapper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (bus.slave)
  );

  initial clk = 1'b0;
  always #7 clk = ~clk;

  localparam logic [79:0] DEMO_CFG = 80'h0080_4020_0000_0010_8421;

  // Reference: term t fires when all required-high inputs are 1 and all
  // required-low inputs are 0; output o is the OR of its connected terms.
  function automatic logic [7:0] model(input logic [79:0] cfg, input logic [7:0] in, input logic en);
    logic [7:0] pos, neg;
    logic [3:0] fire;
    logic [3:0] res;
    for (int t = 0; t < 4; t++) begin
      pos = '0;
      neg = '0;
      for (int i = 0; i < 8; i++) begin
        pos[i] = cfg[16 + 16 * t + 2 * i];
        neg[i] = cfg[16 + 16 * t + 2 * i + 1];
      end
      fire[t] = ((in & pos) == pos) && ((~in & neg) == neg);
    end
    res = '0;
    for (int o = 0; o < 4; o++)
      res[o] = |(fire & cfg[4 * o +: 4]);
    return en ? {4'h0, res} : 8'h00;
  endfunction

  task automatic shift_bit(input logic b);
    bus.uio_in[0] = b;
    #5 bus.uio_in[2] = 1'b1;
    #5 bus.uio_in[2] = 1'b0;
  endtask

  task automatic load_cfg(input logic [79:0] cfg);
    bus.uio_in[1] = 1'b0;
    for (int k = 0; k < 80; k++) shift_bit(cfg[k]);
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #5 rst_n = 1'b1;
    #2;
  endtask

  task automatic expect_out(input string name, input logic [7:0] in, input logic en, input logic [7:0] exp);
    bus.ui_in     = in;
    bus.uio_in[1] = en;
    #1;
    checks++;
    if (bus.uo_out !== exp) begin
      errors++;
      $display("FAIL %s: ui_in=%02h en=%0b uo_out=%02h expected=%02h", name, in, en, bus.uo_out, exp);
    end
  endtask

  task automatic test_reset();
    bus.uio_in = 8'h00;
    bus.ui_in  = 8'h00;
    bus.ena    = 1'b1;
    rst_n      = 1'b1;
    load_cfg(DEMO_CFG);
    bus.uio_in[1] = 1'b1;
    bus.ui_in     = $urandom_range(0, 255);
    rst_n         = 1'b0;
    #2;
    checks++;
    if (bus.uo_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_uo_out: got %02h expected 00", bus.uo_out);
    end
    checks++;
    if (bus.uio_oe !== 8'h00 || bus.uio_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_uio: oe=%02h out=%02h expected 00/00", bus.uio_oe, bus.uio_out);
    end
    // Rising cfg_clk while held in reset must not capture data.
    bus.uio_in[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2 bus.uio_in[2] = 1'b1;
      #2 bus.uio_in[2] = 1'b0;
    end
    rst_n = 1'b1;
    #2;
    for (int k = 0; k < 4; k++) expect_out("reset_dominates_clk", 8'(k * 61), 1'b1, 8'h00);
  endtask

  task automatic test_demo_config();
    logic [7:0] ins [5] = '{8'h00, 8'h01, 8'h04, 8'h08, 8'h80};
    logic [7:0] exps[5] = '{8'h0A, 8'h0A, 8'h0B, 8'h02, 8'h0E};
    do_reset();
    load_cfg(DEMO_CFG);
    for (int k = 0; k < 5; k++) expect_out("demo_cfg", ins[k], 1'b1, exps[k]);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] v;
      v = 8'($urandom);
      expect_out("demo_cfg_rand", v, 1'b1, model(DEMO_CFG, v, 1'b1));
    end
  endtask

  task automatic test_enable();
    expect_out("enable_off", 8'h04, 1'b0, 8'h00);
    expect_out("enable_on", 8'h04, 1'b1, 8'h0B);
  endtask

  task automatic test_all_zero();
    do_reset();
    load_cfg('0);
    for (int v = 0; v < 256; v += 17) expect_out("all_zero", 8'(v), 1'b1, 8'h00);
  endtask

  task automatic test_reset_midload();
    do_reset();
    for (int k = 0; k < 40; k++) shift_bit(DEMO_CFG[k]);
    do_reset();
    load_cfg(DEMO_CFG);
    expect_out("midload_reload", 8'h00, 1'b1, 8'h0A);
    expect_out("midload_reload", 8'h04, 1'b1, 8'h0B);
    expect_out("midload_reload", 8'h08, 1'b1, 8'h02);
    expect_out("midload_reload", 8'h80, 1'b1, 8'h0E);
  endtask

  task automatic test_single_literal();
    logic [79:0] cfg;
    cfg     = '0;
    cfg[0]  = 1'b1;
    cfg[16] = 1'b1;
    do_reset();
    load_cfg(cfg);
    expect_out("single_literal", 8'h01, 1'b1, 8'h01);
    expect_out("single_literal", 8'h00, 1'b1, 8'h00);
  endtask

  task automatic test_random_configs();
    for (int n = 0; n < 10; n++) begin
      logic [79:0] cfg;
      cfg[15:0] = 16'($urandom);
      for (int k = 16; k < 80; k++) cfg[k] = ($urandom_range(0, 7) == 0);
      do_reset();
      load_cfg(cfg);
      for (int j = 0; j < 8; j++) begin
        logic [7:0] v;
        logic       en;
        v  = 8'($urandom);
        en = ($urandom_range(0, 3) != 0);
        expect_out("random_cfg", v, en, model(cfg, v, en));
      end
    end
  endtask

  // Short loads after reset: the j-th of n shifted bits ends up at 80-n+j.
  task automatic test_misaligned();
    for (int n = 0; n < 4; n++) begin
      int          len;
      logic [79:0] cfg;
      logic        bits[$];
      len = $urandom_range(1, 79);
      bits.delete();
      do_reset();
      for (int j = 0; j < len; j++) begin
        bits.push_back(($urandom_range(0, 5) == 0));
        shift_bit(bits[j]);
      end
      cfg = '0;
      foreach (bits[j]) cfg[80 - len + j] = bits[j];
      for (int j = 0; j < 4; j++) begin
        logic [7:0] v;
        v = 8'($urandom);
        expect_out("misaligned", v, 1'b1, model(cfg, v, 1'b1));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_demo_config();
    test_enable();
    test_all_zero();
    test_reset_midload();
    test_single_literal();
    test_random_configs();
    test_misaligned();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
